// File: rtl/pmu_pkg.sv
// Shared defaults and types for the multi-channel power manager.
package pmu_pkg;

  localparam int NUM_CH_DEF    = 3;
  localparam int DIV_W_DEF     = 8;
  localparam int CH_W_DEF      = 2;
  localparam int RESET_DIV_DEF = 1;

  typedef logic [DIV_W_DEF-1:0] div_t;

endpackage

// File: rtl/pmu_div_channel.sv
// One divided-clock channel: counter, active/new divisor, pending flag and
// the glitch-free apply rule (new divisors only land on a falling boundary,
// or immediately when the channel is stopped).
module pmu_div_channel
  import pmu_pkg::*;
#(
  parameter int DIV_W     = DIV_W_DEF,
  parameter int RESET_DIV = RESET_DIV_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic [DIV_W-1:0] load_div,
  output logic             clk_o,
  output logic             pending_o,
  output logic             running_o
);

  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(RESET_DIV);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic [DIV_W-1:0] new_div_q, new_div_d;
  logic             pending_q, pending_d;
  logic             clk_q, clk_d;
  logic             running_q;
  logic             wrap;
  logic             stopped;

  // Next-state: apply a pending divisor at a falling boundary (or at once when
  // stopped), otherwise run the divider; a new load only arrives when idle.
  always_comb begin
    cnt_d     = cnt_q;
    cur_div_d = cur_div_q;
    new_div_d = new_div_q;
    pending_d = pending_q;
    clk_d     = clk_q;
    stopped   = (cur_div_q == '0);
    wrap      = !stopped && (cnt_q == (cur_div_q - DIV_ONE));

    if (pending_q && (stopped || (wrap && clk_q))) begin
      // New divisor always begins on a fresh low half.
      cur_div_d = new_div_q;
      cnt_d     = '0;
      clk_d     = 1'b0;
      pending_d = 1'b0;
    end else if (stopped) begin
      cnt_d = '0;
      clk_d = 1'b0;
    end else if (wrap) begin
      cnt_d = '0;
      clk_d = ~clk_q;
    end else begin
      cnt_d = cnt_q + DIV_ONE;
    end

    if (load_en) begin
      new_div_d = load_div;
      pending_d = 1'b1;
    end
  end

  // State register with synchronous active-low reset back to RESET_DIV.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q     <= '0;
      cur_div_q <= DIV_RST;
      new_div_q <= '0;
      pending_q <= 1'b0;
      clk_q     <= 1'b0;
      running_q <= (DIV_RST != '0);
    end else begin
      cnt_q     <= cnt_d;
      cur_div_q <= cur_div_d;
      new_div_q <= new_div_d;
      pending_q <= pending_d;
      clk_q     <= clk_d;
      running_q <= (cur_div_d != '0);
    end
  end

  assign clk_o     = clk_q;
  assign pending_o = pending_q;
  assign running_o = running_q;

endmodule

// File: rtl/power_manager_multi.sv
// NUM_CH programmable clock dividers behind a valid/ready change port with
// per-channel pending registers and a broadcast mode.
module power_manager_multi
  import pmu_pkg::*;
#(
  parameter int NUM_CH    = NUM_CH_DEF,
  parameter int DIV_W     = DIV_W_DEF,
  parameter int CH_W      = CH_W_DEF,
  parameter int RESET_DIV = RESET_DIV_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              change_valid,
  output logic              change_ready,
  input  logic              change_bcast,
  input  logic [CH_W-1:0]   change_ch,
  input  logic [DIV_W-1:0]  change_div,
  output logic [NUM_CH-1:0] clock_out,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] running
);

  logic [NUM_CH-1:0] sel;
  logic [NUM_CH-1:0] load_en;
  logic              ch_in_range;
  logic              accept;

  // Request decode: a target is ready only when every selected channel is
  // idle; an out-of-range channel index is never ready.
  always_comb begin
    ch_in_range  = ({1'b0, change_ch} < (CH_W+1)'(NUM_CH));
    change_ready = (change_bcast || ch_in_range) && ((sel & pending) == '0);
    accept       = change_valid && change_ready;
    load_en      = sel & {NUM_CH{accept}};
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign sel[gi] = change_bcast || (change_ch == CH_W'(gi));

      pmu_div_channel #(
        .DIV_W     (DIV_W),
        .RESET_DIV (RESET_DIV)
      ) u_ch (
        .clk       (clk),
        .reset     (reset),
        .load_en   (load_en[gi]),
        .load_div  (change_div),
        .clk_o     (clock_out[gi]),
        .pending_o (pending[gi]),
        .running_o (running[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_power_manager_multi.sv
// Self-checking bench: a table of change requests plus hand-written
// sequences for timing corners; measured periods go through a queue.
module tb_power_manager_multi;

  localparam int NUM_CH = 3;
  localparam int DIV_W  = 8;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              change_valid = 1'b0;
  logic              change_bcast = 1'b0;
  logic [CH_W-1:0]   change_ch = '0;
  logic [DIV_W-1:0]  change_div = '0;
  logic              change_ready;
  logic [NUM_CH-1:0] clock_out;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] running;

  power_manager_multi #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .CH_W(CH_W), .RESET_DIV(1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .change_valid (change_valid),
    .change_ready (change_ready),
    .change_bcast (change_bcast),
    .change_ch    (change_ch),
    .change_div   (change_div),
    .clock_out    (clock_out),
    .pending      (pending),
    .running      (running)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       bcast;
    logic [1:0] ch;
    logic [7:0] div;
    logic       exp_ready;
    logic [2:0] exp_pend;
    logic [2:0] exp_run;
    int         exp_half;   // -1 no period check, 0 stopped, >0 half period
    logic [2:0] others_d1;  // channels expected to still run at half period 1
  } vec_t;

  typedef struct {
    int ch;
    int hi;
    int lo;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Drive one request for one edge; returns ready as seen before that edge.
  task automatic send(input logic bc, input logic [1:0] ch, input logic [7:0] dv,
                      output logic rdy);
    change_valid = 1'b1;
    change_bcast = bc;
    change_ch    = ch;
    change_div   = dv;
    #1;
    rdy = change_ready;
    step();
    change_valid = 1'b0;
    change_bcast = 1'b0;
  endtask

  task automatic wait_clear(input logic [2:0] mask, input string name);
    int n;
    n = 0;
    while (((pending & mask) != 3'b000) && (n < 400)) begin
      step();
      n++;
    end
    chk({name, "_pending_clear"}, {29'd0, pending & mask}, 32'd0);
  endtask

  task automatic measure(input int ch, output int hi, output int lo);
    logic prev;
    int n;
    hi = 0;
    lo = 0;
    prev = clock_out[ch];
    n = 0;
    while (n < 700) begin
      step();
      n++;
      if (!prev && clock_out[ch]) break;
      prev = clock_out[ch];
    end
    if (n >= 700) return;
    hi = 1;
    while (n < 700) begin
      step(); n++;
      if (clock_out[ch]) hi++; else break;
    end
    lo = 1;
    while (n < 700) begin
      step(); n++;
      if (!clock_out[ch]) lo++; else break;
    end
  endtask

  task automatic drain_sb();
    exp_t e;
    int hi, lo;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      measure(e.ch, hi, lo);
      chk($sformatf("ch%0d_high_len", e.ch), hi, e.hi);
      chk($sformatf("ch%0d_low_len", e.ch), lo, e.lo);
    end
  endtask

  initial begin
    logic rdy;
    int   highs;
    int   n;

    //            bc   ch     div   rdy  pend    run     half others
    vecs[0] = '{1'b0, 2'd1, 8'd4, 1'b1, 3'b010, 3'b111, 4,  3'b101};
    vecs[1] = '{1'b0, 2'd2, 8'd0, 1'b1, 3'b100, 3'b011, 0,  3'b000};
    vecs[2] = '{1'b0, 2'd2, 8'd3, 1'b1, 3'b100, 3'b111, 3,  3'b000};
    vecs[3] = '{1'b0, 2'd3, 8'd7, 1'b0, 3'b000, 3'b111, -1, 3'b000};
    vecs[4] = '{1'b0, 2'd0, 8'd1, 1'b1, 3'b001, 3'b111, 1,  3'b000};

    // Reset state and the clk/2 start-up pattern.
    repeat (3) step();
    chk("rst_pending", {29'd0, pending}, 32'd0);
    chk("rst_running", {29'd0, running}, 32'h7);
    chk("rst_clock_out", {29'd0, clock_out}, 32'd0);
    #1;
    chk("rst_ready", {31'd0, change_ready}, 32'd1);
    reset = 1'b1;
    step();
    chk("start_c1", {29'd0, clock_out}, 32'h7);
    step();
    chk("start_c2", {29'd0, clock_out}, 32'h0);
    step();
    chk("start_c3", {29'd0, clock_out}, 32'h7);

    // Table-driven requests.
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].bcast, vecs[i].ch, vecs[i].div, rdy);
      chk($sformatf("v%0d_ready", i), {31'd0, rdy}, {31'd0, vecs[i].exp_ready});
      chk($sformatf("v%0d_pending", i), {29'd0, pending}, {29'd0, vecs[i].exp_pend});
      if (vecs[i].exp_ready) wait_clear(3'b111, $sformatf("v%0d", i));
      chk($sformatf("v%0d_running", i), {29'd0, running}, {29'd0, vecs[i].exp_run});
      if (vecs[i].exp_half == 0) begin
        highs = 0;
        for (int k = 0; k < 16; k++) begin
          if (clock_out[vecs[i].ch]) highs++;
          step();
        end
        chk($sformatf("v%0d_stopped_highs", i), highs, 0);
      end else if (vecs[i].exp_half > 0) begin
        sb_q.push_back('{int'(vecs[i].ch), vecs[i].exp_half, vecs[i].exp_half});
        for (int c = 0; c < NUM_CH; c++)
          if (vecs[i].others_d1[c]) sb_q.push_back('{c, 1, 1});
        drain_sb();
      end
    end

    // Stop then restart ch2: apply one cycle after accept, first rise 3 later.
    send(1'b0, 2'd2, 8'd0, rdy);
    wait_clear(3'b100, "stop2");
    chk("stop2_low", {31'd0, clock_out[2]}, 32'd0);
    chk("stop2_running", {31'd0, running[2]}, 32'd0);
    step();
    send(1'b0, 2'd2, 8'd3, rdy);
    chk("restart_ready", {31'd0, rdy}, 32'd1);
    chk("restart_pend", {31'd0, pending[2]}, 32'd1);
    step();
    chk("restart_applied", {31'd0, pending[2]}, 32'd0);
    chk("restart_running", {31'd0, running[2]}, 32'd1);
    chk("restart_a0", {31'd0, clock_out[2]}, 32'd0);
    step();
    chk("restart_a1", {31'd0, clock_out[2]}, 32'd0);
    step();
    chk("restart_a2", {31'd0, clock_out[2]}, 32'd0);
    step();
    chk("restart_a3_rise", {31'd0, clock_out[2]}, 32'd1);

    // Back-to-back requests to ch0 held valid: second stalls until first applies.
    send(1'b0, 2'd0, 8'd5, rdy);
    chk("b2b_first_ready", {31'd0, rdy}, 32'd1);
    change_valid = 1'b1;
    change_ch    = 2'd0;
    change_div   = 8'd2;
    #1;
    chk("b2b_second_stall", {31'd0, change_ready}, 32'd0);
    n = 0;
    while (!change_ready && n < 400) begin
      step();
      #1;
      n++;
    end
    chk("b2b_stall_ended", {31'd0, change_ready}, 32'd1);
    chk("b2b_pend_before", {31'd0, pending[0]}, 32'd0);
    step();
    change_valid = 1'b0;
    chk("b2b_pend_after", {31'd0, pending[0]}, 32'd1);
    wait_clear(3'b001, "b2b");
    sb_q.push_back('{0, 2, 2});
    drain_sb();

    // Broadcast while ch0 pending: waits for ch0, then everything at period 4.
    send(1'b0, 2'd0, 8'd6, rdy);
    change_valid = 1'b1;
    change_bcast = 1'b1;
    change_div   = 8'd2;
    #1;
    chk("bcast_stall", {31'd0, change_ready}, 32'd0);
    n = 0;
    while (!change_ready && n < 400) begin
      step();
      #1;
      n++;
    end
    chk("bcast_ready", {31'd0, change_ready}, 32'd1);
    step();
    change_valid = 1'b0;
    change_bcast = 1'b0;
    chk("bcast_pend", {29'd0, pending}, 32'h7);
    wait_clear(3'b111, "bcast");
    for (int c = 0; c < NUM_CH; c++) sb_q.push_back('{c, 2, 2});
    drain_sb();
    chk("bcast_final_pend", {29'd0, pending}, 32'd0);

    // Reset mid-change discards the pending request and restores RESET_DIV.
    send(1'b0, 2'd1, 8'd9, rdy);
    chk("rst2_pend", {29'd0, pending}, 32'h2);
    reset = 1'b0;
    step();
    chk("rst2_pending", {29'd0, pending}, 32'd0);
    chk("rst2_clock", {29'd0, clock_out}, 32'd0);
    reset = 1'b1;
    step();
    chk("rst2_c1", {29'd0, clock_out}, 32'h7);
    step();
    chk("rst2_c2", {29'd0, clock_out}, 32'h0);
    chk("rst2_running", {29'd0, running}, 32'h7);
    sb_q.push_back('{1, 1, 1});
    drain_sb();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/power_manager_multi.md
Name: power_manager_multi

Overview:
- Parametrised successor to the fixed three-output power manager.
- Generates NUM_CH independently programmable divided clocks from one system clock, with a valid/ready change handshake, per-channel pending registers, a broadcast mode and glitch-free divisor switching at period boundaries.
- Sits between the bus-side speed controller and the clock-gated peripheral domains.

Parameters:
- NUM_CH, 3, number of divided clock outputs.
- DIV_W, 8, divisor width in bits.
- CH_W, 2, channel-select width (>= clog2(NUM_CH)).
- RESET_DIV, 1, divisor loaded into every channel at reset (0 = stopped).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- change_valid  in  1  change request valid.
- change_ready  out  1  request can be accepted this cycle.
- change_bcast  in  1  apply change_div to all channels (ignore change_ch).
- change_ch  in  CH_W  target channel index.
- change_div  in  DIV_W  new divisor D.
- clock_out  out  NUM_CH  divided clocks.
- pending  out  NUM_CH  per-channel change-pending flags.
- running  out  NUM_CH  per-channel active-divisor-nonzero flags.

Behaviour:
- Reset (reset==0 at a clk edge):
  - cur_div[i]=RESET_DIV, cnt[i]=0, clock_out=0, pending=0.
  - running[i]=(RESET_DIV!=0).
  - Reset mid-operation discards pending changes and takes effect on that edge.
- Divider, per channel, with D=cur_div[i]:
  - D==0: clock_out[i] held 0 and cnt held 0.
  - D>=1: cnt counts 0..D-1. At cnt==D-1, cnt wraps to 0 and clock_out[i] toggles. Period is 2*D clk cycles, 50% duty.
  - D==1 gives clk/2.
  - First rising edge of clock_out[i] occurs D cycles after the channel starts from cnt=0, output low.
- Handshake:
  - Accept = change_valid && change_ready at a clk edge.
  - change_ready=1 iff the targeted channel(s) have pending==0. For broadcast, all channels must be non-pending. If change_ch>=NUM_CH, change_ready=0.
  - On accept: new_div[i]<=change_div and pending[i]<=1 for each target, visible the cycle after accept.
  - A held request with change_ready=0 stalls. There is no drop and no overwrite.
- Apply rule (glitch-free), for a channel with pending=1:
  - If running and at wrap with clock_out==1: cur_div<=new_div, cnt<=0, clock_out<=0, pending<=0 on the same edge. The new divisor always starts on a low half.
  - If currently stopped (cur_div==0): apply on the first edge where pending==1, i.e. 1 cycle after accept. Then cnt=0 and clock_out=0.
  - A pending D=0 on a running channel stops it at the next falling boundary, leaving the output low. No runt pulse is permitted.
  - A pending D equal to cur_div still waits for the boundary, then clears pending.
- running[i] = (cur_div[i]!=0), registered with cur_div.
- Simultaneous events:
  - An accept cannot target a pending channel.
  - Apply and a new accept to a different channel in the same cycle are independent.
  - An apply and an accept to the same channel cannot coincide, because change_ready is 0 while that channel is pending.
- Width rules:
  - cnt is DIV_W bits.
  - The compare D-1 uses DIV_W arithmetic, guarded by D!=0.

Decomposition:
- Shared package pmu_pkg holds DIV_W/CH_W defaults, the RESET_DIV default and a typedef div_t = logic [DIV_W-1:0].
- Sub-module pmu_div_channel holds one channel's cnt, cur_div, new_div, pending and apply logic. It has inputs load_en and load_div and outputs clk_o, pending_o and running_o.
- The top instantiates NUM_CH channels via generate and implements the handshake decode.

Test Plan:
- Reset with RESET_DIV=1 -> reset released at cycle 0; every clock_out toggles every cycle (period 2); pending=000; running=111; change_ready=1.
- Change ch1 to D=4 while ch1 runs D=1:
  - Accept at cycle t gives pending[1]=1 at t+1.
  - Switch happens at the next falling boundary of clock_out[1].
  - clock_out[1] then shows low 4 / high 4; ch0 and ch2 are unaffected.
- Stop and restart:
  - ch2 D=0 -> clock_out[2] goes low at its next falling edge and stays low; running[2]=0.
  - Then ch2 D=3 -> applied 1 cycle after accept; first rise 3 cycles after apply.
- Back-to-back to the same channel: two valid requests to ch0 (D=5 then D=2) held valid -> the second stalls with change_ready=0 until pending[0] clears; the final period is 4.
- Broadcast D=2 with ch0 pending -> change_ready=0 until ch0 applies; afterwards all channels settle to period 4 and pending=000.
- Invalid change_ch=3 with NUM_CH=3 -> change_ready=0 and no state change. Asserting reset low mid-change -> pending cleared and all divisors return to RESET_DIV.
